// File: rtl/idex_pkg.sv
// ID/EX pipeline register package: default widths, control bit indices,
// payload field layout and a packed payload type with a packing helper.
package idex_pkg;

    // Default widths of the control field and the datapath payload
    localparam int CTRL_W_DEF = 3;
    localparam int DATA_W_DEF = 160;

    // Control bit indices (WB, M and EX stage groups)
    localparam int CTRL_WB = 0;   // memToReg
    localparam int CTRL_M  = 1;   // memRd | memWr
    localparam int CTRL_EX = 2;   // regDst

    // Payload field widths
    localparam int PC4_W   = 32;
    localparam int BUSA_W  = 32;
    localparam int BUSB_W  = 32;
    localparam int IMM_W   = 32;
    localparam int INSTR_W = 26;
    localparam int FWD_W   = 6;

    // Payload field offsets (LSB position inside the packed payload)
    localparam int FWD_LSB   = 0;
    localparam int INSTR_LSB = FWD_LSB + FWD_W;
    localparam int IMM_LSB   = INSTR_LSB + INSTR_W;
    localparam int BUSB_LSB  = IMM_LSB + IMM_W;
    localparam int BUSA_LSB  = BUSB_LSB + BUSB_W;
    localparam int PC4_LSB   = BUSA_LSB + BUSA_W;

    // Packed payload, most significant field first
    typedef struct packed {
        logic [PC4_W-1:0]   pc4;
        logic [BUSA_W-1:0]  bus_a;
        logic [BUSB_W-1:0]  bus_b;
        logic [IMM_W-1:0]   imm;
        logic [INSTR_W-1:0] instr;
        logic [FWD_W-1:0]   fwd;
    } idex_payload_t;

    // Assemble a payload word from its individual fields
    function automatic idex_payload_t pack_payload(
        input logic [PC4_W-1:0]   pc4,
        input logic [BUSA_W-1:0]  bus_a,
        input logic [BUSB_W-1:0]  bus_b,
        input logic [IMM_W-1:0]   imm,
        input logic [INSTR_W-1:0] instr,
        input logic [FWD_W-1:0]   fwd
    );
        idex_payload_t p;
        p.pc4   = pc4;
        p.bus_a = bus_a;
        p.bus_b = bus_b;
        p.imm   = imm;
        p.instr = instr;
        p.fwd   = fwd;
        return p;
    endfunction

endpackage

// File: rtl/idex_pipe_slice.sv
// One ID/EX register slice: valid/ctrl/data registers with asynchronous
// reset, flush (kills valid and ctrl, keeps data), stall (hold) and load.
module idex_pipe_slice
    import idex_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_stall,
    input  logic              i_valid,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Valid and control: flush kills them, stall holds, otherwise load
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (!i_stall) begin
            r_valid <= i_valid;
            r_ctrl  <= i_ctrl;
        end
    end

    // Payload: untouched by flush, only loaded on an advance edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= '0;
        end else if (!i_flush && !i_stall) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register: DEPTH chained slices carrying valid, control and
// payload from decode to execute, with stall, flush and bubble insertion.
// Optional macro IDEX_PERF_CNT_EN adds saturating bubble/stall counters.
module idex_pipe_reg
    import idex_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    input  logic [CTRL_W-1:0] i_id_ctrl,
    input  logic [DATA_W-1:0] i_id_data,
    input  logic              i_bubble,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic              o_ex_valid,
    output logic [CTRL_W-1:0] o_ex_ctrl,
    output logic [DATA_W-1:0] o_ex_data
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  o_bubble_cnt,
    output logic [CNT_W-1:0]  o_stall_cnt
`endif
);

    // A zero-depth register or a zero-width counter cannot be built
    generate
        if (DEPTH < 1 || CNT_W < 1) begin : g_bad_param
            $error("idex_pipe_reg: DEPTH and CNT_W must both be >= 1");
        end
    endgenerate

    // Chain nodes: index 0 is the masked decode input, index k+1 is slice k output
    logic              w_valid [0:DEPTH];
    logic [CTRL_W-1:0] w_ctrl  [0:DEPTH];
    logic [DATA_W-1:0] w_data  [0:DEPTH];

    // Bubble or an invalid decode slot enters slice0 as a NOP with zero control,
    // which keeps ex_valid==0 implying ex_ctrl==0 down the whole chain
    assign w_valid[0] = i_id_valid & ~i_bubble;
    assign w_ctrl[0]  = (i_bubble | ~i_id_valid) ? '0 : i_id_ctrl;
    assign w_data[0]  = i_id_data;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slice
            idex_pipe_slice #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_slice (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_flush (i_flush),
                .i_stall (i_stall),
                .i_valid (w_valid[gi]),
                .i_ctrl  (w_ctrl[gi]),
                .i_data  (w_data[gi]),
                .o_valid (w_valid[gi+1]),
                .o_ctrl  (w_ctrl[gi+1]),
                .o_data  (w_data[gi+1])
            );
        end
    endgenerate

    assign o_ex_valid = w_valid[DEPTH];
    assign o_ex_ctrl  = w_ctrl[DEPTH];
    assign o_ex_data  = w_data[DEPTH];

`ifdef IDEX_PERF_CNT_EN
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_advance;

    // An advance edge is one that neither flushes nor stalls
    assign w_advance = ~i_flush & ~i_stall;

    // Saturating event counters: bubbles on advance edges, stalls not overridden by flush
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_advance && i_bubble && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
            if (i_stall && !i_flush && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign o_bubble_cnt = r_bubble_cnt;
    assign o_stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Self-checking bench for idex_pipe_reg: a DEPTH=1 and a DEPTH=3 instance
// share one stimulus stream and are checked against a history-based model.
// Build with IDEX_PERF_CNT_EN defined to also check the counters.
module tb_idex_pipe_reg;
    import idex_pkg::*;

    localparam int CW = 3;
    localparam int DW = 160;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [CW-1:0] id_ctrl;
    logic [DW-1:0] id_data;
    logic          bubble;
    logic          stall;
    logic          flush;

    logic          v1, v3;
    logic [CW-1:0] c1, c3;
    logic [DW-1:0] d1, d3;
`ifdef IDEX_PERF_CNT_EN
    logic [3:0]    bc1, sc1, bc3, sc3;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    idex_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(1), .CNT_W(4)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_ctrl(id_ctrl),
        .i_id_data(id_data), .i_bubble(bubble), .i_stall(stall), .i_flush(flush),
        .o_ex_valid(v1), .o_ex_ctrl(c1), .o_ex_data(d1)
`ifdef IDEX_PERF_CNT_EN
        , .o_bubble_cnt(bc1), .o_stall_cnt(sc1)
`endif
    );

    idex_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(3), .CNT_W(4)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_ctrl(id_ctrl),
        .i_id_data(id_data), .i_bubble(bubble), .i_stall(stall), .i_flush(flush),
        .o_ex_valid(v3), .o_ex_ctrl(c3), .o_ex_data(d3)
`ifdef IDEX_PERF_CNT_EN
        , .o_bubble_cnt(bc3), .o_stall_cnt(sc3)
`endif
    );

    // Reference model: history of captured entries, newest first. The output of
    // a DEPTH-D register is the entry captured D advance edges ago (zero if none).
    typedef struct packed {
        logic          v;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t q1[$];
    ent_t q3[$];
    int   bcnt, scnt;

    task automatic model_reset();
        q1.delete();
        q3.delete();
        bcnt = 0;
        scnt = 0;
    endtask

    task automatic model_edge();
        ent_t e;
        if (rst) return;
        if (flush) begin
            // every in-flight instruction is killed, payload stays
            for (int i = 0; i < q1.size(); i++) begin
                e = q1[i]; e.v = 1'b0; e.c = '0; q1[i] = e;
            end
            for (int i = 0; i < q3.size(); i++) begin
                e = q3[i]; e.v = 1'b0; e.c = '0; q3[i] = e;
            end
        end else if (!stall) begin
            e.v = id_valid && !bubble;
            e.c = (bubble || !id_valid) ? '0 : id_ctrl;
            e.d = id_data;
            q1.push_front(e);
            q3.push_front(e);
            while (q1.size() > 1) void'(q1.pop_back());
            while (q3.size() > 3) void'(q3.pop_back());
            if (bubble && bcnt < 15) bcnt++;
        end
        if (stall && !flush && scnt < 15) scnt++;
    endtask

    function automatic ent_t exp1();
        if (q1.size() >= 1) return q1[0];
        return '0;
    endfunction

    function automatic ent_t exp3();
        if (q3.size() >= 3) return q3[2];
        return '0;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock edge: inputs are stable at the edge, outputs sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        id_valid = 1'b0; bubble = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; id_valid = 1'b1; id_ctrl = 3'b111; id_data = rnd_data();
        bubble = 1'b0; stall = 1'b0; flush = 1'b0;
        model_reset();
        #12;
        total++;
        if ({v1, c1, d1} !== '0) begin
            bad++; $display("FAIL reset_d1 got v=%0b c=%0b d=%h required all zero", v1, c1, d1);
        end
        total++;
        if ({v3, c3, d3} !== '0) begin
            bad++; $display("FAIL reset_d3 got v=%0b c=%0b d=%h required all zero", v3, c3, d3);
        end
`ifdef IDEX_PERF_CNT_EN
        total++;
        if ({bc1, sc1} !== 8'h00) begin
            bad++; $display("FAIL reset_cnt got bubble=%0d stall=%0d required 0", bc1, sc1);
        end
`endif
        rst = 1'b0;
        id_valid = 1'b0;
    endtask

    task automatic test_capture();
        logic [DW-1:0] a;
        a = pack_payload(32'h0040_0004, 32'h1111_2222, 32'h3333_4444,
                         32'hFFFF_FF80, 26'h123_4567, 6'h2A);
        id_valid = 1'b1; id_ctrl = 3'b101; id_data = a; bubble = 1'b0;
        step();
        total++;
        if (v1 !== 1'b1 || c1 !== 3'b101 || d1 !== a) begin
            bad++; $display("FAIL capture got v=%0b c=%b d=%h required v=1 c=101 d=%h", v1, c1, d1, a);
        end
    endtask

    task automatic test_bubble();
        logic [DW-1:0] b;
        b = pack_payload(32'h0040_0008, 32'hDEAD_BEEF, 32'hCAFE_F00D,
                         32'h0000_0010, 26'h3FF_FFFF, 6'h15);
        id_valid = 1'b1; id_ctrl = 3'b111; id_data = b; bubble = 1'b1;
        step();
        total++;
        if (v1 !== 1'b0 || c1 !== 3'b000 || d1 !== b) begin
            bad++; $display("FAIL bubble got v=%0b c=%b d=%h required v=0 c=000 d=%h", v1, c1, d1, b);
        end
        bubble = 1'b0;
    endtask

    task automatic test_stall_stream();
        logic [DW-1:0] item [5];
        logic [DW-1:0] seen [$];
        int            first_edge [5];
        int            exp_edge [5];
        int            nxt;
        ent_t          e;
        exp_edge = '{3, 4, 5, 6, 7};
        for (int k = 0; k < 5; k++) begin
            item[k] = rnd_data();
            first_edge[k] = -1;
        end
        do_reset();
        nxt = 0;
        for (int edge_i = 0; edge_i < 12; edge_i++) begin
            stall = (edge_i == 2);
            if (nxt < 5) begin
                id_valid = 1'b1; id_ctrl = 3'(nxt + 1); id_data = item[nxt];
            end else begin
                id_valid = 1'b0; id_ctrl = 3'b111; id_data = rnd_data();
            end
            step();
            if (!stall && nxt < 5) nxt++;
            e = exp3();
            total++;
            if ({v3, c3, d3} !== {e.v, e.c, e.d}) begin
                bad++; $display("FAIL stream_cycle edge=%0d got v=%0b c=%b required v=%0b c=%b", edge_i, v3, c3, e.v, e.c);
            end
            if (v3 && (seen.size() == 0 || seen[$] !== d3)) begin
                seen.push_back(d3);
                for (int k = 0; k < 5; k++)
                    if (d3 === item[k] && first_edge[k] < 0) first_edge[k] = edge_i;
            end
        end
        stall = 1'b0;
        total++;
        if (seen.size() != 5) begin
            bad++; $display("FAIL stream_count got %0d distinct outputs required 5", seen.size());
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (first_edge[k] != exp_edge[k]) begin
                bad++; $display("FAIL stream_order item=%0d got edge %0d required edge %0d", k, first_edge[k], exp_edge[k]);
            end
        end
    endtask

    task automatic test_stall_flush();
        logic [DW-1:0] j [3];
        do_reset();
        for (int k = 0; k < 3; k++) begin
            j[k] = rnd_data();
            id_valid = 1'b1; id_ctrl = 3'b011; id_data = j[k];
            step();
        end
        total++;
        if (v3 !== 1'b1 || d3 !== j[0]) begin
            bad++; $display("FAIL sf_filled got v=%0b required v=1 with first item", v3);
        end
        stall = 1'b1; flush = 1'b1; id_data = rnd_data();
        step();
        stall = 1'b0; flush = 1'b0;
        total++;
        if (v3 !== 1'b0 || c3 !== 3'b000 || d3 !== j[0]) begin
            bad++; $display("FAIL sf_flush got v=%0b c=%b d=%h required v=0 c=000 d=%h", v3, c3, d3, j[0]);
        end
        id_valid = 1'b0;
        for (int k = 1; k < 3; k++) begin
            id_data = rnd_data();
            step();
            total++;
            if (v3 !== 1'b0 || c3 !== 3'b000 || d3 !== j[k]) begin
                bad++; $display("FAIL sf_drain k=%0d got v=%0b c=%b d=%h required v=0 c=000 d=%h", k, v3, c3, d3, j[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] c_dat, d_dat;
        realtime       t_assert;
        int            edges_seen;
        c_dat = rnd_data();
        d_dat = rnd_data();
        do_reset();
        id_valid = 1'b1; id_ctrl = 3'b110; id_data = c_dat;
        step();
        total++;
        if (v1 !== 1'b1 || c1 !== 3'b110) begin
            bad++; $display("FAIL areset_pre got v=%0b c=%b required v=1 c=110", v1, c1);
        end
        #2;
        edges_seen = 0;
        fork
            begin @(posedge clk); edges_seen = 1; end
            begin #2; end
        join_any
        disable fork;
        t_assert = $realtime;
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if (edges_seen != 0 || {v1, c1, d1} !== '0 || {v3, c3, d3} !== '0) begin
            bad++; $display("FAIL areset_clear got v1=%0b c1=%b v3=%0b edges=%0d required zeros before edge (t=%0t)", v1, c1, v3, edges_seen, t_assert);
        end
        #1;
        rst = 1'b0;
        id_valid = 1'b1; id_ctrl = 3'b011; id_data = d_dat;
        step();
        total++;
        if (v1 !== 1'b1 || c1 !== 3'b011 || d1 !== d_dat) begin
            bad++; $display("FAIL areset_first got v=%0b c=%b d=%h required v=1 c=011 d=%h", v1, c1, d1, d_dat);
        end
        total++;
        if ($isunknown({v3, c3, d3})) begin
            bad++; $display("FAIL areset_noX got X on depth-3 outputs");
        end
    endtask

    task automatic test_random();
        ent_t e;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            id_valid = ($urandom_range(3) != 0);
            id_ctrl  = 3'($urandom);
            id_data  = rnd_data();
            bubble   = ($urandom_range(4) == 0);
            stall    = ($urandom_range(4) == 0);
            flush    = ($urandom_range(9) == 0);
            step();
            e = exp1();
            total++;
            if ({v1, c1, d1} !== {e.v, e.c, e.d}) begin
                bad++; $display("FAIL rand_d1 cyc=%0d got v=%0b c=%b d=%h required v=%0b c=%b d=%h", cyc, v1, c1, d1, e.v, e.c, e.d);
            end
            e = exp3();
            total++;
            if ({v3, c3, d3} !== {e.v, e.c, e.d}) begin
                bad++; $display("FAIL rand_d3 cyc=%0d got v=%0b c=%b d=%h required v=%0b c=%b d=%h", cyc, v3, c3, d3, e.v, e.c, e.d);
            end
`ifdef IDEX_PERF_CNT_EN
            total++;
            if (bc3 !== 4'(bcnt) || sc3 !== 4'(scnt) || bc1 !== 4'(bcnt) || sc1 !== 4'(scnt)) begin
                bad++; $display("FAIL rand_cnt cyc=%0d got bubble=%0d stall=%0d required bubble=%0d stall=%0d", cyc, bc3, sc3, bcnt, scnt);
            end
`endif
        end
        id_valid = 1'b0; bubble = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

`ifdef IDEX_PERF_CNT_EN
    task automatic test_counters();
        do_reset();
        id_valid = 1'b1; id_ctrl = 3'b001; bubble = 1'b1;
        for (int k = 0; k < 20; k++) begin
            id_data = rnd_data();
            step();
        end
        bubble = 1'b0;
        total++;
        if (bc1 !== 4'hF || sc1 !== 4'h0) begin
            bad++; $display("FAIL cnt_sat got bubble=%h stall=%h required bubble=f stall=0", bc1, sc1);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if (bc1 !== 4'h0 || bc3 !== 4'h0) begin
            bad++; $display("FAIL cnt_clear got bubble=%h required 0", bc1);
        end
        #1;
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_capture();
        test_bubble();
        test_stall_stream();
        test_stall_flush();
        test_async_reset();
        test_random();
`ifdef IDEX_PERF_CNT_EN
        test_counters();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
